// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle FSM sequencing fetch, decode, execute, memory and writeback
// with a shared ready-wait timeout that traps on a stalled memory.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        zero_flag,
  output logic        ir_write,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        halted,
  output logic        trap,
  output logic [2:0]  state_o
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP} state_t;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] op, opm1;
  logic is_nop, is_alu, is_shift, is_ldi, is_ld, is_st, is_beq, is_jmp, is_halt, is_ill;
  logic waiting, timeout, in_exec, unused_bits;
  assign op          = instr[15:12];
  assign opm1        = op - 4'd1;
  assign unused_bits = ^instr[11:0];
  assign is_nop      = op == 4'h0;
  assign is_alu      = op >= 4'h1 && op <= 4'h6;
  assign is_shift    = op == 4'h5 || op == 4'h6;
  assign is_ldi      = op == 4'h7;
  assign is_ld       = op == 4'h8;
  assign is_st       = op == 4'h9;
  assign is_beq      = op == 4'hA;
  assign is_jmp      = op == 4'hB;
  assign is_halt     = op == 4'hF;
  assign is_ill      = op >= 4'hC && op <= 4'hE;
  // One counter serves both fetch and data waits; ready on the last allowed cycle still wins.
  assign waiting = (state == FETCH && !imem_ready) || (state == MEM && !dmem_ready);
  assign timeout = waiting && cnt == CW'(MEM_TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = imem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE:  nxt = is_ill ? TRAP : is_halt ? HALT : is_nop ? FETCH : EXEC;
      EXEC:    nxt = (is_ld || is_st) ? MEM : (is_beq || is_jmp) ? FETCH : WB;
      MEM:     nxt = dmem_ready ? (is_st ? FETCH : WB) : timeout ? TRAP : MEM;
      WB:      nxt = FETCH;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (waiting && !timeout) ? cnt + 1'b1 : '0;
    end
  // Reset parks the FSM in FETCH, so only the FETCH-driven strobes need gating with rst_n.
  assign in_exec     = state == EXEC;
  assign imem_req    = rst_n && state == FETCH;
  assign ir_write    = imem_req && imem_ready;
  assign pc_write    = ir_write || (in_exec && (is_jmp || (is_beq && zero_flag)));
  assign pc_src      = (in_exec && is_beq) ? 2'b01 : (in_exec && is_jmp) ? 2'b10 : 2'b00;
  assign dmem_req    = state == MEM;
  assign dmem_we     = dmem_req && is_st;
  assign reg_write   = state == WB;
  assign wb_sel      = !reg_write ? 2'b00 : is_ld ? 2'b01 : is_ldi ? 2'b10 : 2'b00;
  assign alu_op      = !in_exec ? 3'b000 : is_alu ? opm1[2:0] : is_ldi ? 3'b110 : is_beq ? 3'b001 : 3'b000;
  assign alu_src_imm = in_exec && (is_shift || is_ldi || is_ld || is_st);
  assign ImmSrc      = !(state inside {DECODE, EXEC, MEM, WB}) ? 2'b00 :
                       (is_ld || is_st || is_beq) ? 2'b01 : is_shift ? 2'b10 : 2'b00;
  assign halted      = state == HALT;
  assign trap        = state == TRAP;
  assign state_o     = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven and randomized per-cycle checks of multicycle_controller
// against an instruction-level trace model.
module tb_multicycle_controller;
  localparam int TO = 15;
  logic clk = 0, rst_n = 1;
  logic [15:0] instr = '0;
  logic imem_ready = 0, dmem_ready = 0, zero_flag = 0;
  logic imem_req, dmem_req, dmem_we, ir_write, alu_src_imm, reg_write, pc_write, halted, trap;
  logic [1:0] ImmSrc, wb_sel, pc_src;
  logic [2:0] alu_op, state_o;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       dmem_req, dmem_we, reg_write;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] imm;
    logic       halted, trap;
  } out_t;
  typedef struct {
    out_t o;
    logic ir, dr;
  } cyc_t;
  typedef struct {
    logic [3:0] op;
    logic       z;
    int         wi, wd, lat;
    logic [2:0] es;
  } vec_t;
  out_t act;
  cyc_t tr[$];
  vec_t vecs[22];
  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .zero_flag(zero_flag),
    .ir_write(ir_write), .ImmSrc(ImmSrc), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
    .halted(halted), .trap(trap), .state_o(state_o)
  );
  assign act = {state_o, imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write,
                wb_sel, alu_op, alu_src_imm, ImmSrc, halted, trap};
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic out_t base(logic [2:0] st, logic [3:0] op);
    out_t o = '0;
    o.st = st;
    if (st >= 3'd1 && st <= 3'd4)
      o.imm = (op inside {4'h8, 4'h9, 4'hA}) ? 2'd1 : (op inside {4'h5, 4'h6}) ? 2'd2 : 2'd0;
    return o;
  endfunction
  function automatic void push(out_t o, logic ir, logic dr);
    tr.push_back('{o: o, ir: ir, dr: dr});
  endfunction
  function automatic void term(logic [2:0] st);
    out_t o = base(st, 4'h0);
    o.halted = st == 3'd5;
    o.trap   = st == 3'd6;
    for (int k = 0; k < 4; k++) push(o, 1'($urandom), 1'($urandom));
  endfunction
  // Expected cycle-by-cycle trace of one instruction, with the ready inputs to apply.
  function automatic void build(logic [3:0] op, logic z, int wi, int wd);
    out_t o;
    tr.delete();
    o = base(3'd0, op);
    o.imem_req = 1;
    for (int k = 0; k < (wi < TO ? wi : TO); k++) push(o, 1'b0, 1'($urandom));
    if (wi >= TO) begin term(3'd6); return; end
    o.ir_write = 1;
    o.pc_write = 1;
    push(o, 1'b1, 1'($urandom));
    push(base(3'd1, op), 1'($urandom), 1'($urandom));
    if (op >= 4'hC && op <= 4'hE) begin term(3'd6); return; end
    if (op == 4'hF) begin term(3'd5); return; end
    if (op == 4'h0) return;
    o = base(3'd2, op);
    if (op >= 4'h1 && op <= 4'h6) begin
      o.alu_op  = 3'(op - 1);
      o.alu_src = op >= 4'h5;
    end
    if (op == 4'h7) begin o.alu_op = 3'd6; o.alu_src = 1; end
    if (op == 4'h8 || op == 4'h9) o.alu_src = 1;
    if (op == 4'hA) begin o.alu_op = 3'd1; o.pc_src = 2'd1; o.pc_write = z; end
    if (op == 4'hB) begin o.pc_src = 2'd2; o.pc_write = 1; end
    push(o, 1'($urandom), 1'($urandom));
    if (op == 4'hA || op == 4'hB) return;
    if (op == 4'h8 || op == 4'h9) begin
      o = base(3'd3, op);
      o.dmem_req = 1;
      o.dmem_we  = op == 4'h9;
      for (int k = 0; k < (wd < TO ? wd : TO); k++) push(o, 1'($urandom), 1'b0);
      if (wd >= TO) begin term(3'd6); return; end
      push(o, 1'($urandom), 1'b1);
      if (op == 4'h9) return;
    end
    o = base(3'd4, op);
    o.reg_write = 1;
    o.wb_sel    = op == 4'h8 ? 2'd1 : op == 4'h7 ? 2'd2 : 2'd0;
    push(o, 1'($urandom), 1'($urandom));
  endfunction
  task automatic reset_dut();
    out_t e = '0;
    imem_ready = 1;
    dmem_ready = 1;
    rst_n = 0;
    #1 chk("reset outputs", 32'(act), 32'(e));
    @(posedge clk);
    #1 chk("reset held", 32'(act), 32'(e));
    imem_ready = 0;
    rst_n = 1;
    e.imem_req = 1;
    #1 chk("release fetch", 32'(act), 32'(e));
  endtask
  task automatic run(logic [3:0] op, logic z, int wi, int wd, int abort,
                     output int lat, output logic [2:0] es);
    build(op, z, wi, wd);
    instr = {op, 12'($urandom)};
    zero_flag = z;
    lat = 0;
    es = 3'd7;
    foreach (tr[i]) begin
      imem_ready = tr[i].ir;
      dmem_ready = tr[i].dr;
      @(negedge clk);
      chk($sformatf("op%h cyc%0d", op, i), 32'(act), 32'(tr[i].o));
      if (tr[i].o.st < 3'd5) lat++;
      if (i == abort) begin
        #2 imem_ready = 1;
        rst_n = 0;
        #1 chk("abort outputs", 32'(act), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        imem_ready = 0;
        es = state_o;
        return;
      end
      @(posedge clk);
      #1;
    end
    es = state_o;
    if (es >= 3'd5) reset_dut();
  endtask
  initial begin
    int lat, r;
    logic [2:0] es;
    logic [3:0] op;
    vecs = '{
      '{4'h1, 1'b0, 0, 0, 4, 3'd0}, '{4'h2, 1'b0, 0, 0, 4, 3'd0}, '{4'h3, 1'b0, 0, 0, 4, 3'd0},
      '{4'h4, 1'b0, 0, 0, 4, 3'd0}, '{4'h5, 1'b0, 0, 0, 4, 3'd0}, '{4'h6, 1'b0, 0, 0, 4, 3'd0},
      '{4'h7, 1'b0, 0, 0, 4, 3'd0}, '{4'h8, 1'b0, 0, 0, 5, 3'd0}, '{4'h8, 1'b0, 0, 3, 8, 3'd0},
      '{4'h9, 1'b0, 0, 0, 4, 3'd0}, '{4'hA, 1'b1, 0, 0, 3, 3'd0}, '{4'hA, 1'b0, 0, 0, 3, 3'd0},
      '{4'hB, 1'b0, 0, 0, 3, 3'd0}, '{4'h0, 1'b0, 0, 0, 2, 3'd0}, '{4'h9, 1'b0, 0, 14, 18, 3'd0},
      '{4'h8, 1'b0, 0, 15, 18, 3'd6}, '{4'h1, 1'b0, 14, 0, 18, 3'd0}, '{4'h1, 1'b0, 15, 0, 15, 3'd6},
      '{4'hC, 1'b0, 0, 0, 2, 3'd6}, '{4'hD, 1'b0, 0, 0, 2, 3'd6}, '{4'hE, 1'b0, 0, 0, 2, 3'd6},
      '{4'hF, 1'b0, 0, 0, 2, 3'd5}
    };
    #2 reset_dut();
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].z, vecs[i].wi, vecs[i].wd, -1, lat, es);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d end state", i), 32'(es), 32'(vecs[i].es));
    end
    run(4'h9, 1'b0, 0, 3, 3, lat, es);
    chk("store abort state", 32'(es), 32'd0);
    run(4'h1, 1'b0, 0, 0, -1, lat, es);
    chk("post-abort add latency", lat, 4);
    run(4'h8, 1'b0, 0, 2, 4, lat, es);
    chk("load abort state", 32'(es), 32'd0);
    run(4'h7, 1'b0, 1, 0, -1, lat, es);
    chk("post-abort ldi latency", lat, 5);
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      op = r < 88 ? 4'($urandom_range(0, 11)) : 4'($urandom_range(12, 15));
      run(op, 1'($urandom), r == 95 ? TO : int'($urandom_range(0, 3)),
          r == 96 ? TO : r == 97 ? TO - 1 : int'($urandom_range(0, 3)), -1, lat, es);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles to wait for any memory ready before trapping.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr  input  16  instruction register contents; opcode is instr[15:12].
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_ready  input  1  fetch data valid this cycle.
REQ-007 dmem_req  output  1  data memory access request.
REQ-008 dmem_we  output  1  data access is a write; valid only with dmem_req.
REQ-009 dmem_ready  input  1  data access complete this cycle.
REQ-010 zero_flag  input  1  ALU zero result for BEQ.
REQ-011 ir_write  output  1  load instruction register.
REQ-012 ImmSrc  output  2  immediate select: 00=imm8 [11:4], 01=signed imm6 [5:0], 10=imm3 [5:3].
REQ-013 alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR, 110 PASS-B.
REQ-014 alu_src_imm  output  1  ALU operand B from immediate.
REQ-015 reg_write  output  1  register file write strobe.
REQ-016 wb_sel  output  2  00 ALU result, 01 memory data, 10 immediate.
REQ-017 pc_write  output  1  PC update strobe.
REQ-018 pc_src  output  2  00 PC+1, 01 PC+imm6, 10 imm8 absolute.
REQ-019 halted  output  1  core halted (HALT executed).
REQ-020 trap  output  1  illegal opcode or memory timeout; sticky.
REQ-021 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-022 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
REQ-023 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 SHR, 7 LDI, 8 LOAD, 9 STORE, A BEQ, B JMP, F HALT; C/D/E illegal.
REQ-024 FETCH: imem_req=1; on imem_ready SHALL pulse ir_write and pc_write (pc_src=00) in that cycle and go to DECODE; otherwise stay.
REQ-025 DECODE: illegal opcode -> TRAP; HALT -> HALT; NOP -> FETCH; all others -> EXEC.
REQ-026 ImmSrc SHALL be driven combinationally from instr in DECODE through WB: LDI/JMP 00, LOAD/STORE/BEQ 01, SHL/SHR 10, else 00.
REQ-027 EXEC: ALU ops SHALL set alu_op per REQ-013 (SHL/SHR with alu_src_imm=1, ADD..OR with 0) and go to WB; LOAD/STORE SHALL set alu_op=ADD, alu_src_imm=1 and go to MEM; LDI -> WB.
REQ-028 EXEC, BEQ: pc_write=zero_flag, pc_src=01, alu_op=SUB, -> FETCH; JMP: pc_write=1, pc_src=10, -> FETCH.
REQ-029 MEM: dmem_req=1, dmem_we=1 for STORE; on dmem_ready STORE -> FETCH, LOAD -> WB.
REQ-030 WB: reg_write=1 for exactly one cycle, wb_sel 00 (ALU ops), 01 (LOAD), 10 (LDI); then -> FETCH.
REQ-031 A wait counter SHALL clear on entering FETCH or MEM, increment each cycle ready is low; reaching MEM_TIMEOUT while ready still low SHALL go to TRAP, so ready on the MEM_TIMEOUT-th waiting cycle still succeeds.
REQ-032 HALT and TRAP SHALL be absorbing until reset; halted=1 in HALT, trap=1 in TRAP; all strobes 0 there.
REQ-033 All strobe outputs (ir_write, pc_write, reg_write, dmem_req, imem_req) SHALL be 0 in any state not listed as asserting them.
REQ-034 Latency: ALU op/LDI 4 cycles, LOAD 5, STORE 4, BEQ/JMP 3, NOP 2, with zero-wait memory.

Reset
REQ-035 rst_n low SHALL immediately force state FETCH, wait counter 0, and all outputs 0 except imem_req, which becomes 1 once rst_n deasserts.
REQ-036 Reset asserted mid-MEM SHALL abort the access: dmem_req drops asynchronously and no reg_write follows.

Verification
REQ-037 ADD (0x1xxx), zero-wait memory -> ir_write in cycle 1, alu_op=000 in EXEC, reg_write=1, wb_sel=00 in cycle 4, imem_req again in cycle 5.
REQ-038 LOAD with dmem_ready delayed 3 cycles -> ImmSrc=01, dmem_req high 4 cycles, dmem_we=0, reg_write with wb_sel=01 in the following cycle.
REQ-039 BEQ with zero_flag=1 -> pc_write=1, pc_src=01 in EXEC; zero_flag=0 -> pc_write=0; both return to FETCH.
REQ-040 imem_ready held low -> trap=1 after MEM_TIMEOUT waiting cycles and stays 1 until rst_n low.
REQ-041 Opcode 0xC -> TRAP from DECODE; opcode 0xF -> halted=1, no further imem_req.
REQ-042 rst_n pulsed low in MEM of STORE -> dmem_req=0 immediately, state_o=0 after release, next fetch proceeds normally.
